riscv_fetch_queue: RTL and testbench

Instruction-fetch front end for the pipelined RISCVCPU. Owns the PC, issues word reads to a synchronous instruction memory, and buffers returned instructions in a small FIFO that feeds the decode stage. A redirect from execute (branch/jump) flushes buffered and in-flight fetches. Decode sees a NOP (0x00000013) whenever no valid instruction is available.

---
 rtl/riscv_fetch_queue.sv | 133 +++++++++++++
 tb/tb_riscv_fetch_queue.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_fetch_queue.sv
// Instruction-fetch front end: owns the PC, issues word reads to a synchronous
// imem and buffers returns in a FIFO for decode. Optional macro: FETCH_BYPASS_EN.
module riscv_fetch_queue #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter int              IMEM_AW  = 10,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic               clock,
  input  logic               reset,
  output logic               imem_req,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
  input  logic               redirect_valid,
  input  logic [XLEN-1:0]    redirect_pc,
  output logic               if_valid,
  output logic [31:0]        if_instr,
  output logic [XLEN-1:0]    if_pc,
  input  logic               id_ready
);

  localparam int              PTR_W    = $clog2(DEPTH);
  localparam int              CNT_W    = PTR_W + 1;
  localparam logic [31:0]     NOP      = 32'h0000_0013;
  localparam logic [XLEN-1:0] PC_ALIGN = ~XLEN'(3);

  // Handshake: an entry leaves the queue on a rising edge where if_valid and
  // id_ready are both high and neither reset nor redirect_valid is asserted.

  logic [XLEN-1:0]  pc_q, pc_d;
  logic             inflight_q, inflight_d;
  logic [XLEN-1:0]  inflight_pc_q, inflight_pc_d;
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [XLEN-1:0]  fifo_pc_q    [DEPTH];
  logic [31:0]      fifo_instr_q [DEPTH];

  logic             flush;
  logic [XLEN-1:0]  flush_pc;
  logic [CNT_W-1:0] occupancy;
  logic             fifo_empty;
  logic             bypass;
  logic             push;
  logic             pop;

  always_comb begin
    flush      = reset || redirect_valid;
    flush_pc   = (reset ? RESET_PC : redirect_pc) & PC_ALIGN;
    occupancy  = count_q + CNT_W'(inflight_q);
    fifo_empty = (count_q == '0);
    imem_req   = !flush && (occupancy < CNT_W'(DEPTH));
    imem_addr  = pc_q[IMEM_AW+1:2];
  end

`ifdef FETCH_BYPASS_EN
  // A return landing on an empty queue is shown to decode in the same cycle.
  assign bypass = fifo_empty && inflight_q && !flush;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed return consumed by decode never enters the queue.
  assign pop  = !fifo_empty && id_ready && !flush;
  assign push = inflight_q && !flush && !(bypass && id_ready);

  always_comb begin
    pc_d          = pc_q;
    inflight_d    = inflight_q;
    inflight_pc_d = inflight_pc_q;
    head_d        = head_q;
    tail_d        = tail_q;
    count_d       = count_q;
    if (flush) begin
      pc_d       = flush_pc;
      inflight_d = 1'b0;
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
    end else begin
      inflight_d = imem_req;
      if (imem_req) begin
        pc_d          = pc_q + XLEN'(4);
        inflight_pc_d = pc_q;
      end
      if (push) tail_d = tail_q + PTR_W'(1);
      if (pop)  head_d = head_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q          <= RESET_PC & PC_ALIGN;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      fifo_pc_q[tail_q]    <= inflight_pc_q;
      fifo_instr_q[tail_q] <= imem_rdata;
    end
  end

  always_comb begin
    if_valid = !fifo_empty || bypass;
    if_instr = NOP;
    if_pc    = '0;
    if (!fifo_empty) begin
      if_instr = fifo_instr_q[head_q];
      if_pc    = fifo_pc_q[head_q];
    end
`ifdef FETCH_BYPASS_EN
    else if (bypass) begin
      if_instr = imem_rdata;
      if_pc    = inflight_pc_q;
    end
`endif
  end

endmodule

// File: tb/tb_riscv_fetch_queue.sv
// Bench for riscv_fetch_queue: directed scenarios plus randomized ready/redirect/reset,
// checked against an expected in-order PC stream held in a scoreboard queue.
module tb_riscv_fetch_queue;

  localparam int          XLEN     = 32;
  localparam int          DEPTH    = 4;
  localparam int          IMEM_AW  = 10;
  localparam logic [31:0] RESET_PC = 32'h0;
  localparam logic [31:0] NOP      = 32'h0000_0013;
`ifdef FETCH_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic               clock;
  logic               reset;
  logic               imem_req;
  logic [IMEM_AW-1:0] imem_addr;
  logic [31:0]        imem_rdata;
  logic               redirect_valid;
  logic [XLEN-1:0]    redirect_pc;
  logic               if_valid;
  logic [31:0]        if_instr;
  logic [XLEN-1:0]    if_pc;
  logic               id_ready;

  riscv_fetch_queue #(
    .XLEN(XLEN), .DEPTH(DEPTH), .IMEM_AW(IMEM_AW), .RESET_PC(RESET_PC)
  ) dut (
    .clock(clock), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .id_ready(id_ready)
  );

  // clock / reset block
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // instruction memory: word k holds 0x00100093+k, garbage when not requested
  function automatic logic [31:0] mem_word(input logic [IMEM_AW-1:0] a);
    return 32'h0010_0093 + 32'(a);
  endfunction

  always @(posedge clock) imem_rdata <= imem_req ? mem_word(imem_addr) : $urandom;

  // scoreboard
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [63:0] exp_q[$];
  logic [31:0] gen_pc;
  int          outstanding;
  bit          mon_en = 0;
  logic [63:0] mon_exp;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic top_up();
    while (exp_q.size() < 32) begin
      exp_q.push_back({gen_pc, mem_word(gen_pc[IMEM_AW+1:2])});
      gen_pc = gen_pc + 32'd4;
    end
  endtask

  task automatic restart_stream(input logic [31:0] start);
    exp_q.delete();
    gen_pc = start & ~32'h3;
    top_up();
  endtask

  // monitor: samples on the falling edge, acts on what the next rising edge commits
  always @(negedge clock) begin
    if (mon_en) begin
      if (!if_valid) begin
        check("idle_instr", 64'(if_instr), 64'(NOP));
        check("idle_pc", 64'(if_pc), 64'h0);
      end
      if (reset || redirect_valid) begin
        check("req_during_flush", 64'(imem_req), 64'h0);
        outstanding = 0;
      end else begin
        if (if_valid && id_ready) begin
          if (exp_q.size() == 0) begin
            check("sb_nonempty", 64'h0, 64'h1);
          end else begin
            mon_exp = exp_q.pop_front();
            check("deliver", {if_pc, if_instr}, mon_exp);
            top_up();
          end
          outstanding--;
        end
        if (imem_req) outstanding++;
        check("occupancy_le_depth", 64'(outstanding <= DEPTH), 64'h1);
      end
    end
  end

  // driver tasks
  task automatic measure_latency(input string name);
    int lat = 0;
    while (!if_valid && lat < 10) begin
      @(negedge clock);
      lat++;
    end
    check(name, 64'(lat), 64'(LAT));
  endtask

  task automatic apply_reset(input int cycles);
    @(posedge clock); #1;
    reset = 1'b1;
    redirect_valid = 1'b0;
    restart_stream(RESET_PC);
    repeat (cycles) @(posedge clock);
    #1 reset = 1'b0;
    mon_en = 1;
    @(negedge clock);
    check("rst_if_valid", 64'(if_valid), 64'h0);
    check("rst_if_instr", 64'(if_instr), 64'(NOP));
    check("rst_if_pc", 64'(if_pc), 64'h0);
    check("rst_imem_addr", 64'(imem_addr), 64'(RESET_PC[IMEM_AW+1:2]));
    check("first_req", 64'(imem_req), 64'h1);
  endtask

  task automatic redirect(input logic [31:0] target, input bit pre_valid, input bit measure);
    logic [31:0] t;
    t = target & ~32'h3;
    @(posedge clock); #1;
    redirect_valid = 1'b1;
    redirect_pc = target;
    restart_stream(target);
    @(negedge clock);
    if (pre_valid) check("redirect_pre_valid", 64'(if_valid), 64'h1);
    @(posedge clock); #1;
    redirect_valid = 1'b0;
    @(negedge clock);
    check("redirect_if_valid", 64'(if_valid), 64'h0);
    check("redirect_addr", 64'(imem_addr), 64'(t[IMEM_AW+1:2]));
    check("redirect_req", 64'(imem_req), 64'h1);
    if (measure) measure_latency("redirect_latency");
  endtask

  task automatic run(input int n, input bit ready, input bit expect_valid);
    repeat (n) begin
      @(posedge clock); #1;
      id_ready = ready;
      @(negedge clock);
      if (expect_valid) check("throughput", 64'(if_valid), 64'h1);
    end
  endtask

  initial begin
    reset = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    id_ready = 1'b1;
    outstanding = 0;

    // sustained stream from reset, one instruction per cycle
    apply_reset(2);
    measure_latency("startup_latency");
    run(20, 1'b1, 1'b1);

    // long decode stall fills the queue and stops fetch
    run(10, 1'b0, 1'b0);
    check("stall_req_off", 64'(imem_req), 64'h0);
    check("stall_full", 64'(outstanding), 64'(DEPTH));
    check("stall_valid", 64'(if_valid), 64'h1);
    run(15, 1'b1, 1'b1);

    // redirect with three buffered entries and one in flight
    id_ready = 1'b0;
    apply_reset(1);
    run(3, 1'b0, 1'b0);
    redirect(32'h23, 1'b1, 1'b1);
    run(12, 1'b1, 1'b0);

    // redirect coinciding with a valid head and id_ready
    run(5, 1'b1, 1'b1);
    redirect(32'h100, 1'b1, 1'b1);
    run(10, 1'b1, 1'b0);

    // PC wraps past 0xFFFFFFFC, then a one-cycle reset mid-stream
    redirect(32'hFFFF_FFF4, 1'b0, 1'b1);
    run(8, 1'b1, 1'b1);
    apply_reset(1);
    measure_latency("reset_restart_latency");
    run(10, 1'b1, 1'b1);

    // randomized ready, redirect and reset traffic
    for (int i = 0; i < 600; i++) begin
      int r;
      @(posedge clock); #1;
      id_ready = ($urandom_range(0, 3) != 0);
      r = $urandom_range(0, 99);
      if (r < 4) begin
        reset = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = $urandom;
        restart_stream(redirect_pc);
      end else if (r == 4) begin
        redirect_valid = 1'b0;
        reset = 1'b1;
        restart_stream(RESET_PC);
      end else begin
        redirect_valid = 1'b0;
        reset = 1'b0;
      end
    end
    @(posedge clock); #1;
    reset = 1'b0;
    redirect_valid = 1'b0;
    run(10, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
